// File: rtl/unstripe_lane_sched_if.sv
// rtl/unstripe_lane_sched_if.sv - two-lane input and recombined output bundle for unstripe_lane_sched
interface unstripe_lane_sched_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] lane_0;
  logic              valid_0;
  logic [DATA_W-1:0] lane_1;
  logic              valid_1;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              lane_sel;

  modport master (
    output lane_0, valid_0, lane_1, valid_1,
    input  data_out, valid_out, lane_sel
  );

  modport slave (
    input  lane_0, valid_0, lane_1, valid_1,
    output data_out, valid_out, lane_sel
  );
endinterface

// File: rtl/unstripe_lane_sched.sv
// rtl/unstripe_lane_sched.sv - round-robin two-lane unstripe scheduler with skew and overflow detection
module unstripe_lane_sched #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int MAX_SKEW = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  unstripe_lane_sched_if.slave    bus,
  input  logic                    clear_err,
  output logic                    skew_err,
  output logic                    ovf_err,
  output logic [$clog2(DEPTH):0]  fill_0,
  output logic [$clog2(DEPTH):0]  fill_1
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int SW = $clog2(MAX_SKEW + 1);
  localparam logic [FW-1:0] FULL      = FW'(DEPTH);
  localparam logic [SW-1:0] SKEW_LAST = SW'(MAX_SKEW - 1);

  typedef enum logic [1:0] {RUN_L0, RUN_L1, ERROR} state_t;
  state_t state, state_next;

  logic [DATA_W-1:0] mem [2][DEPTH];
  logic [AW-1:0]     wr_ptr [2];
  logic [AW-1:0]     rd_ptr [2];
  logic [FW-1:0]     fill   [2];
  logic [DATA_W-1:0] in_data [2];
  logic [1:0]        in_valid;
  logic [SW-1:0]     skew_cnt, skew_next;

  logic [1:0]        push, pop, ovf_hit;
  logic              cur_lane, starve, skew_hit, err_enter;

  logic [DATA_W-1:0] data_q;
  logic              valid_q, sel_q;

  assign in_data[0]    = bus.lane_0;
  assign in_data[1]    = bus.lane_1;
  assign in_valid      = {bus.valid_1, bus.valid_0};
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.lane_sel  = sel_q;
  assign fill_0        = fill[0];
  assign fill_1        = fill[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN_L0;
    else        state <= state_next;
  end

  // Pop decisions use the registered fill, so a word pushed this edge is never popped this edge.
  always_comb begin
    state_next = state;
    push       = 2'b00;
    pop        = 2'b00;
    ovf_hit    = 2'b00;
    cur_lane   = 1'b0;
    starve     = 1'b0;
    skew_hit   = 1'b0;
    skew_next  = '0;
    err_enter  = 1'b0;
    case (state)
      RUN_L0, RUN_L1: begin
        cur_lane      = (state == RUN_L1);
        push          = in_valid;
        pop[cur_lane] = (fill[cur_lane] != '0);
        for (int i = 0; i < 2; i++)
          ovf_hit[i] = push[i] && (fill[i] == FULL) && !pop[i];
        starve = (fill[cur_lane] == '0) && (fill[~cur_lane] != '0);
        if (starve) begin
          if (skew_cnt == SKEW_LAST) skew_hit  = 1'b1;
          else                       skew_next = skew_cnt + SW'(1);
        end
        if ((|ovf_hit) || skew_hit) begin
          err_enter  = 1'b1;
          state_next = ERROR;
        end else if (pop[cur_lane]) begin
          state_next = cur_lane ? RUN_L0 : RUN_L1;
        end
      end
      ERROR: begin
        if (clear_err) state_next = RUN_L0;
      end
      default: state_next = RUN_L0;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= in_data[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        fill[i]   <= '0;
      end
      skew_cnt <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sel_q    <= 1'b0;
      skew_err <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      skew_cnt <= skew_next;
      valid_q  <= 1'b0;
      // Entering or sitting in ERROR drops everything buffered on both lanes.
      if (err_enter || state == ERROR) begin
        for (int i = 0; i < 2; i++) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
          fill[i]   <= '0;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
          if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
          fill[i] <= fill[i] + FW'(push[i]) - FW'(pop[i]);
        end
        if (pop[cur_lane]) begin
          data_q  <= mem[cur_lane][rd_ptr[cur_lane]];
          valid_q <= 1'b1;
          sel_q   <= cur_lane;
        end
      end
      if (|ovf_hit) ovf_err  <= 1'b1;
      if (skew_hit) skew_err <= 1'b1;
      if (state == ERROR && clear_err) begin
        ovf_err  <= 1'b0;
        skew_err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_unstripe_lane_sched.sv
// tb/tb_unstripe_lane_sched.sv - directed self-checking bench for unstripe_lane_sched
module tb_unstripe_lane_sched;
  logic       clk = 1'b0;
  logic       reset;
  logic       clear_err;
  logic       skew_err, ovf_err;
  logic [2:0] fill_0, fill_1;
  int         checks = 0;
  int         errors = 0;

  unstripe_lane_sched_if #(.DATA_W(32)) bus ();

  unstripe_lane_sched #(.DATA_W(32), .DEPTH(4), .MAX_SKEW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .clear_err (clear_err),
    .skew_err  (skew_err),
    .ovf_err   (ovf_err),
    .fill_0    (fill_0),
    .fill_1    (fill_1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1);
    bus.valid_0 = v0;
    bus.lane_0  = d0;
    bus.valid_1 = v1;
    bus.lane_1  = d1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    clear_err = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    #1 reset = 1'b0;
    #2;
    checks++;
    if ({bus.data_out, bus.valid_out, bus.lane_sel, skew_err, ovf_err} !== 36'h0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h v=%b sel=%b skew=%b ovf=%b expected all 0",
               bus.data_out, bus.valid_out, bus.lane_sel, skew_err, ovf_err);
    end
    checks++;
    if ({fill_0, fill_1} !== 6'h0) begin
      errors++;
      $display("FAIL reset_fill: got fill_0=%0d fill_1=%0d expected 0 0", fill_0, fill_1);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_in_order();
    logic [31:0] w [4];
    logic        exp_sel;
    w[0] = 32'hFFFF_FFFF; w[1] = 32'hEEEE_EEEE; w[2] = 32'hDDDD_DDDD; w[3] = 32'hCCCC_CCCC;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) set_in(i % 2 == 0, w[i], i % 2 == 1, w[i]);
      else       set_in(1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      if (i > 0) begin
        exp_sel = ((i - 1) % 2 == 1);
        checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== w[i-1] || bus.lane_sel !== exp_sel) begin
          errors++;
          $display("FAIL in_order_word%0d: got v=%b data=%h sel=%b expected v=1 data=%h sel=%b",
                   i - 1, bus.valid_out, bus.data_out, bus.lane_sel, w[i-1], exp_sel);
        end
      end
    end
    tick();
    checks++;
    if (bus.valid_out !== 1'b0 || bus.data_out !== 32'hCCCC_CCCC) begin
      errors++;
      $display("FAIL in_order_idle: got v=%b data=%h expected v=0 data=cccccccc",
               bus.valid_out, bus.data_out);
    end
  endtask

  task automatic test_skew_absorb();
    set_in(1'b0, 32'h0, 1'b1, 32'h0000_0004);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    set_in(1'b1, 32'h0000_0003, 1'b0, 32'h0);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (bus.valid_out !== 1'b0 || fill_0 !== 3'd1 || fill_1 !== 3'd1) begin
      errors++;
      $display("FAIL skew_absorb_buffered: got v=%b fill_0=%0d fill_1=%0d expected v=0 1 1",
               bus.valid_out, fill_0, fill_1);
    end
    tick();
    checks++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== 32'h0000_0003 || bus.lane_sel !== 1'b0) begin
      errors++;
      $display("FAIL skew_absorb_first: got v=%b data=%h sel=%b expected v=1 data=00000003 sel=0",
               bus.valid_out, bus.data_out, bus.lane_sel);
    end
    tick();
    checks++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== 32'h0000_0004 || bus.lane_sel !== 1'b1) begin
      errors++;
      $display("FAIL skew_absorb_second: got v=%b data=%h sel=%b expected v=1 data=00000004 sel=1",
               bus.valid_out, bus.data_out, bus.lane_sel);
    end
    checks++;
    if (skew_err !== 1'b0) begin
      errors++;
      $display("FAIL skew_absorb_flag: got skew_err=%b expected 0", skew_err);
    end
  endtask

  task automatic test_skew_limit();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 32'h0, 1'b1, 32'h9999_9999);
      tick();
    end
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (fill_1 !== 3'd4 || skew_err !== 1'b0) begin
      errors++;
      $display("FAIL skew_limit_fill: got fill_1=%0d skew_err=%b expected 4 0", fill_1, skew_err);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (skew_err !== 1'b0 || bus.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL skew_limit_7th: got skew_err=%b v=%b expected 0 0", skew_err, bus.valid_out);
    end
    tick();
    checks++;
    if (skew_err !== 1'b1 || ovf_err !== 1'b0 || fill_0 !== 3'd0 || fill_1 !== 3'd0 || bus.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL skew_limit_8th: got skew=%b ovf=%b fill_0=%0d fill_1=%0d v=%b expected 1 0 0 0 0",
               skew_err, ovf_err, fill_0, fill_1, bus.valid_out);
    end
    set_in(1'b1, 32'h1234_5678, 1'b1, 32'h8765_4321);
    tick();
    tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (fill_0 !== 3'd0 || fill_1 !== 3'd0 || bus.valid_out !== 1'b0 || skew_err !== 1'b1) begin
      errors++;
      $display("FAIL error_ignores_input: got fill_0=%0d fill_1=%0d v=%b skew=%b expected 0 0 0 1",
               fill_0, fill_1, bus.valid_out, skew_err);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++;
    if (skew_err !== 1'b0) begin
      errors++;
      $display("FAIL skew_clear: got skew_err=%b expected 0", skew_err);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 32'h0, 1'b1, 32'h5000_0000 + i);
      tick();
      if (i == 3) begin
        checks++;
        if (ovf_err !== 1'b0 || fill_1 !== 3'd4) begin
          errors++;
          $display("FAIL overflow_4th: got ovf=%b fill_1=%0d expected 0 4", ovf_err, fill_1);
        end
      end
    end
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (ovf_err !== 1'b1 || skew_err !== 1'b0 || fill_1 !== 3'd0) begin
      errors++;
      $display("FAIL overflow_5th: got ovf=%b skew=%b fill_1=%0d expected 1 0 0", ovf_err, skew_err, fill_1);
    end
  endtask

  task automatic test_recovery();
    tick();
    checks++;
    if (ovf_err !== 1'b1 || bus.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL recovery_sticky: got ovf=%b v=%b expected 1 0", ovf_err, bus.valid_out);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++;
    if (ovf_err !== 1'b0 || skew_err !== 1'b0) begin
      errors++;
      $display("FAIL recovery_flags: got ovf=%b skew=%b expected 0 0", ovf_err, skew_err);
    end
    set_in(1'b1, 32'hAAAA_AAAA, 1'b1, 32'h9999_9999);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checks++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== 32'hAAAA_AAAA || bus.lane_sel !== 1'b0) begin
      errors++;
      $display("FAIL recovery_first: got v=%b data=%h sel=%b expected v=1 data=aaaaaaaa sel=0",
               bus.valid_out, bus.data_out, bus.lane_sel);
    end
    tick();
    checks++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== 32'h9999_9999 || bus.lane_sel !== 1'b1) begin
      errors++;
      $display("FAIL recovery_second: got v=%b data=%h sel=%b expected v=1 data=99999999 sel=1",
               bus.valid_out, bus.data_out, bus.lane_sel);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) begin
      set_in(i == 3, 32'h0000_0A00, 1'b1, 32'h0000_0B10 + i);
      tick();
    end
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checks++;
    if (bus.data_out !== 32'h0000_0A00 || bus.lane_sel !== 1'b0 || fill_1 !== 3'd4) begin
      errors++;
      $display("FAIL full_pre: got data=%h sel=%b fill_1=%0d expected 00000a00 0 4",
               bus.data_out, bus.lane_sel, fill_1);
    end
    set_in(1'b0, 32'h0, 1'b1, 32'h0000_0B14);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (ovf_err !== 1'b0 || fill_1 !== 3'd4 || bus.data_out !== 32'h0000_0B10 || bus.valid_out !== 1'b1) begin
      errors++;
      $display("FAIL full_push_pop: got ovf=%b fill_1=%0d data=%h v=%b expected 0 4 00000b10 1",
               ovf_err, fill_1, bus.data_out, bus.valid_out);
    end
  endtask

  task automatic test_mid_reset();
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.data_out, bus.valid_out, bus.lane_sel, skew_err, ovf_err, fill_0, fill_1} !== 42'h0) begin
      errors++;
      $display("FAIL mid_reset_async: got data=%h v=%b sel=%b fill_0=%0d fill_1=%0d expected all 0",
               bus.data_out, bus.valid_out, bus.lane_sel, fill_0, fill_1);
    end
    tick();
    reset = 1'b1;
    set_in(1'b0, 32'h0, 1'b1, 32'h1111_1111);
    tick();
    set_in(1'b1, 32'h2222_2222, 1'b0, 32'h0);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checks++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== 32'h2222_2222 || bus.lane_sel !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_first: got v=%b data=%h sel=%b expected v=1 data=22222222 sel=0",
               bus.valid_out, bus.data_out, bus.lane_sel);
    end
    tick();
    checks++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== 32'h1111_1111 || bus.lane_sel !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_second: got v=%b data=%h sel=%b expected v=1 data=11111111 sel=1",
               bus.valid_out, bus.data_out, bus.lane_sel);
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_skew_absorb();
    test_skew_limit();
    test_overflow();
    test_recovery();
    test_full_push_pop();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
